// File: rtl/calc_pkg.sv
// calc_display shared types and constants.
// Status codes and active-low segment glyphs.
package calc_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [1:0] STATUS_ERR   = 2'b00;
  localparam logic [1:0] STATUS_BUSY  = 2'b01;
  localparam logic [1:0] STATUS_READY = 2'b10;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_R     = 7'h2F;

  typedef enum logic [1:0] {
    GLY_NONE = 2'd0,
    GLY_E    = 2'd1,
    GLY_R    = 2'd2
  } glyph_t;

endpackage

// File: rtl/seg7_decoder.sv
// Seven-segment glyph decoder, active-low {g,f,e,d,c,b,a}.
// Override glyph wins over blank, blank wins over value.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  glyph_t     glyph,
  output seg_t       seg
);

  seg_t digit;

  // BCD value to glyph; 10..15 render as a dash
  always_comb begin
    digit = SEG_DASH;
    unique case (value)
      4'd0: digit = 7'h40;
      4'd1: digit = 7'h79;
      4'd2: digit = 7'h24;
      4'd3: digit = 7'h30;
      4'd4: digit = 7'h19;
      4'd5: digit = 7'h12;
      4'd6: digit = 7'h02;
      4'd7: digit = 7'h78;
      4'd8: digit = 7'h00;
      4'd9: digit = 7'h10;
      default: digit = SEG_DASH;
    endcase
  end

  // select override, blank or digit
  always_comb begin
    if (glyph == GLY_E)
      seg = SEG_E;
    else if (glyph == GLY_R)
      seg = SEG_R;
    else if (blank)
      seg = SEG_BLANK;
    else
      seg = digit;
  end

endmodule

// File: rtl/calc_display.sv
// Calculator display receiver: capture, commit,
// error latch and multiplexed seven-segment scan.
module calc_display
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            status,
  input  logic [3:0]            data,
  input  logic [3:0]            pos,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg,
  output logic                  dp,
  output logic                  frame_done,
  output logic                  frame_drop,
  output logic                  err
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  logic [3:0]            shadow [NUM_DIGITS];
  logic [3:0]            disp   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen;
  logic [1:0]            prev;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         scan;

  logic                  cap;
  logic                  commit;
  logic                  full;
  logic [IW-1:0]         pidx;
  logic [NUM_DIGITS-1:0] zero_above;
  logic                  acc;
  logic                  blank_cur;
  glyph_t                gly;
  seg_t                  seg_nxt;

  assign dp   = 1'b1;
  assign pidx = pos[IW-1:0];
  assign full = &seen;

  assign cap =
    (status == STATUS_ERR || status == STATUS_BUSY) &&
    (32'(pos) < NUM_DIGITS);

  assign commit =
    (prev == STATUS_ERR || prev == STATUS_BUSY) &&
    (status == STATUS_READY);

  // capture into shadow, commit full frames, pulse outcome
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        disp[i]   <= '0;
      end
      seen       <= '0;
      prev       <= STATUS_READY;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      prev       <= status;
      frame_done <= commit && full;
      frame_drop <= commit && !full;
      if (cap) begin
        shadow[pidx] <= data;
        seen[pidx]   <= 1'b1;
      end
      if (commit) begin
        seen <= '0;
        if (full) disp <= shadow;
      end
    end
  end

  // sticky error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (status == STATUS_ERR)
      err <= 1'b1;
  end

  // refresh divider and scan index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      scan <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      if (32'(scan) == NUM_DIGITS - 1)
        scan <= '0;
      else
        scan <= scan + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // zero_above[i]: every digit from i upward is zero
  always_comb begin
    zero_above = '0;
    acc        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc           = acc && (disp[i] == 4'd0);
      zero_above[i] = acc;
    end
  end

  // glyph selection for the scanned digit
  always_comb begin
    gly       = GLY_NONE;
    blank_cur = 1'b0;
    if (err) begin
      if (32'(scan) == 2)
        gly = GLY_E;
      else if (32'(scan) < 2)
        gly = GLY_R;
      else
        blank_cur = 1'b1;
    end else begin
      blank_cur = BLANK_LEADING &&
                  (scan != '0) &&
                  zero_above[scan];
    end
  end

  seg7_decoder u_dec (
    .value (disp[scan]),
    .blank (blank_cur),
    .glyph (gly),
    .seg   (seg_nxt)
  );

  // registered digit enable and segments
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << scan);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Self-checking bench for calc_display.
// Spec-level model plus directed literal checks.
module tb_calc_display;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;

  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic       fd0, fd1, fdr0, fdr1, err0, err1;

  int total = 0;
  int bad = 0;

  calc_display #(
    .NUM_DIGITS(8), .REFRESH_DIV(4), .BLANK_LEADING(1'b1)
  ) dut0 (
    .clock(clock), .reset(reset), .status(status),
    .data(data), .pos(pos), .an(an0), .seg(seg0),
    .dp(dp0), .frame_done(fd0), .frame_drop(fdr0),
    .err(err0)
  );

  calc_display #(
    .NUM_DIGITS(8), .REFRESH_DIV(4), .BLANK_LEADING(1'b0)
  ) dut1 (
    .clock(clock), .reset(reset), .status(status),
    .data(data), .pos(pos), .an(an1), .seg(seg1),
    .dp(dp1), .frame_done(fd1), .frame_drop(fdr1),
    .err(err1)
  );

  always #5 clock = ~clock;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int         m_sh [8];
  bit         m_seen [8];
  int         m_disp [8];
  bit         m_err;
  int         m_prev;
  int         m_cnt;
  int         m_scan;
  logic [7:0] x_an;
  logic [6:0] x_seg0, x_seg1;
  bit         x_fd, x_fdr;

  function automatic logic [6:0] glyph(int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int i, bit bl);
    bit allz;
    if (m_err) begin
      if (i == 2) return 7'h06;
      if (i < 2) return 7'h2F;
      return 7'h7F;
    end
    allz = 1;
    for (int j = i; j < 8; j++)
      if (m_disp[j] != 0) allz = 0;
    if (bl && i > 0 && allz) return 7'h7F;
    return glyph(m_disp[i]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_sh[i] = 0; m_seen[i] = 0; m_disp[i] = 0;
    end
    m_err = 0; m_prev = 2; m_cnt = 0; m_scan = 0;
    x_an = 8'hFF; x_seg0 = 7'h7F; x_seg1 = 7'h7F;
    x_fd = 0; x_fdr = 0;
  endtask

  task automatic m_step();
    int st, p;
    bit com, ful;
    st = int'(status);
    p = int'(pos);
    x_an = ~(8'd1 << m_scan);
    x_seg0 = exp_seg(m_scan, 1'b1);
    x_seg1 = exp_seg(m_scan, 1'b0);
    ful = 1;
    for (int i = 0; i < 8; i++)
      if (!m_seen[i]) ful = 0;
    com = (m_prev < 2) && (st == 2);
    x_fd = com && ful;
    x_fdr = com && !ful;
    if (com) begin
      if (ful) m_disp = m_sh;
      for (int i = 0; i < 8; i++) m_seen[i] = 0;
    end else if (st < 2 && p < 8) begin
      m_sh[p] = int'(data);
      m_seen[p] = 1;
    end
    if (st == 0) m_err = 1;
    m_prev = st;
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_scan = (m_scan + 1) % 8;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  // every-cycle compare against the model
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("cmp an0", an0, x_an);
        check("cmp an1", an1, x_an);
        check("cmp seg0", seg0, x_seg0);
        check("cmp seg1", seg1, x_seg1);
        check("cmp dp", {dp0, dp1}, 2'b11);
        check("cmp done", {fd0, fd1}, {x_fd, x_fd});
        check("cmp drop", {fdr0, fdr1}, {x_fdr, x_fdr});
        check("cmp err", {err0, err1}, {m_err, m_err});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(int st, int p, int d);
    @(negedge clock);
    status = 2'(st);
    pos = 4'(p);
    data = 4'(d);
  endtask

  task automatic send(int st, int v[8], int n);
    for (int i = 0; i < n; i++) drive(st, i, v[i]);
  endtask

  task automatic go_ready(bit want_done, string nm);
    drive(2, 0, 0);
    @(negedge clock);
    check({nm, " done"}, fd0, want_done);
    check({nm, " drop"}, fdr0, !want_done);
    @(negedge clock);
    check({nm, " pulse end"}, {fd0, fdr0}, 2'b00);
  endtask

  task automatic see(int d, logic [6:0] want, bit sel,
                     string nm);
    logic [7:0] en;
    bit hit;
    en = ~(8'd1 << d);
    hit = 0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clock);
      if (an0 == en) hit = 1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: digit %0d never scanned", nm, d);
    end else begin
      check(nm, sel ? seg1 : seg0, want);
    end
  endtask

  int fa[8], fb[8], fc[8], fz[8], fe[8];

  initial begin
    fa = '{3, 2, 1, 0, 0, 0, 0, 0};
    fb = '{9, 9, 9, 9, 9, 9, 9, 9};
    fc = '{5, 4, 3, 2, 1, 0, 0, 0};
    fz = '{0, 0, 0, 0, 0, 0, 0, 0};
    fe = '{8, 8, 8, 8, 8, 8, 8, 8};

    #1 reset = 1'b0;
    #1;
    check("rst an", an0, 8'hFF);
    check("rst seg", seg0, 7'h7F);
    check("rst dp", dp0, 1'b1);
    check("rst pulses", {fd0, fdr0}, 2'b00);
    check("rst err", err0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // full frame "123"
    send(1, fa, 8);
    go_ready(1'b1, "full");
    see(0, 7'h30, 0, "full d0");
    see(1, 7'h24, 0, "full d1");
    see(2, 7'h79, 0, "full d2");
    see(3, 7'h7F, 0, "full d3");
    see(7, 7'h7F, 0, "full d7");
    see(3, 7'h40, 1, "noblank d3");

    // short frame dropped, then full frame
    send(1, fb, 6);
    go_ready(1'b0, "short");
    see(0, 7'h30, 0, "short keep d0");
    send(1, fc, 8);
    go_ready(1'b1, "next");
    see(0, 7'h12, 0, "next d0");
    see(4, 7'h79, 0, "next d4");
    see(5, 7'h7F, 0, "next d5");
    see(5, 7'h40, 1, "next nb d5");

    // dash and out-of-range position
    drive(1, 0, 7);
    drive(1, 1, 12);
    drive(1, 9, 5);
    for (int i = 2; i < 8; i++) drive(1, i, 0);
    go_ready(1'b1, "dash");
    see(0, 7'h78, 0, "dash d0");
    see(1, 7'h3F, 0, "dash d1");
    see(2, 7'h7F, 0, "dash d2");

    // all-zero frame
    send(1, fz, 8);
    go_ready(1'b1, "zero");
    see(0, 7'h40, 0, "zero d0");
    see(1, 7'h7F, 0, "zero d1");
    see(5, 7'h40, 1, "zero nb d5");
    see(0, 7'h40, 1, "zero nb d0");

    // error pattern
    send(1, fa, 8);
    go_ready(1'b1, "pre err");
    send(0, fe, 8);
    repeat (3) drive(0, 7, 8);
    @(negedge clock);
    check("err set", err0, 1'b1);
    see(2, 7'h06, 0, "err d2");
    see(1, 7'h2F, 0, "err d1");
    see(0, 7'h2F, 0, "err d0");
    see(4, 7'h7F, 0, "err d4");
    go_ready(1'b1, "err commit");
    see(2, 7'h06, 0, "err keep d2");
    see(0, 7'h2F, 1, "err keep nb d0");
    see(6, 7'h7F, 0, "err keep d6");
    check("err sticky", err0, 1'b1);

    // async reset mid-frame
    send(1, fc, 4);
    @(negedge clock);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    check("arst an", an0, 8'hFF);
    check("arst seg", seg0, 7'h7F);
    check("arst err", err0, 1'b0);
    check("arst pulses", {fd0, fdr0}, 2'b00);
    for (int i = 4; i < 8; i++) drive(1, i, fc[i]);
    go_ready(1'b0, "arst");
    check("arst err after", err0, 1'b0);
    see(0, 7'h40, 0, "arst d0");
    see(1, 7'h7F, 0, "arst d1");

    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
